fp_dot_accum: RTL and testbench
===============================

# fp_dot_accum

Streaming IEEE-754 single-precision dot-product engine: accepts `len` operand pairs over a valid/ready stream, multiplies each pair in a MUL_STAGES-deep pipeline, accumulates the products into a running sum, and presents the final sum on a valid/ready result port. It is the next generation of the team's `Add`/`Mul` arithmetic blocks: it adds reset, flow control, a vector-length counter and a control FSM. It sits between an operand fetch stage and the result writeback in the kernel datapath.

## Interface
- WIDTH, 32, operand/result width; only 32 (fp32) is supported, other values are an elaboration error
- MUL_STAGES, 2, multiplier pipeline depth, ≥1
- LEN_W, 8, width of the vector-length input
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous and active-low
- start  in  1  begin a new dot product; sampled only in IDLE
- len  in  LEN_W  number of operand pairs; latched on accepted start
- busy  out  1  high in every state except IDLE
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair accepted when in_valid && in_ready
- a, b  in  WIDTH  fp32 operands
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- result  out  WIDTH  fp32 accumulated sum
- ovf  out  1  sticky overflow flag (only with FP_DOT_OVF_FLAG_EN)

## Operation
- FSM states: IDLE, ACCUM, DRAIN, DONE.
- IDLE: start=1, len≠0 → latch len, clear acc to +0, clear issued/retired counters → ACCUM. start=1, len=0 → acc=+0 → DONE. start ignored outside IDLE.
- ACCUM: in_ready = (issued < len). Each handshake increments issued and pushes a*b into the multiplier pipe with a valid bit. issued==len → DRAIN (the transition happens on the edge that accepts the last pair).
- DRAIN: in_ready=0; keep retiring products. retired==len → DONE.
- Retire: each valid product exiting the pipe updates acc ← fp_add(acc, product) and increments retired; retirement occurs in ACCUM and DRAIN alike. The pipe never stalls, because out_valid cannot be asserted while products are in flight.
- DONE: out_valid=1, result=acc, held stable until out_ready=1 → IDLE on that edge.
- Multiply rules: either operand zero → +0; sign = XOR of signs; 48-bit mantissa product truncated; biased exponent >254 → ±inf (exp 0xFF, mant 0); <1 → signed zero.
- Add rules: zero operand passes the other through; larger exponent wins; smaller operand is aligned by right shift with 1 guard bit and truncated; carry-out → shift right, exp+1; single-step left normalisation; exact cancellation (mantissa difference 0) → +0.
- No NaN generation; inf inputs are treated as ordinary exponent-0xFF values.

## Timing
- Reset values: busy=0, in_ready=0, out_valid=0, result=0x00000000, ovf=0; FSM=IDLE, all counters 0, all pipe valid bits 0.
- A reset during ACCUM or DRAIN flushes in-flight products; no retirement follows the reset edge.
- A pair accepted on edge k retires into acc on edge k+MUL_STAGES.
- Last pair accepted on edge k → out_valid high after edge k+MUL_STAGES+1.
- len=0: out_valid high one cycle after the start edge.
- Back-to-back pairs are accepted every cycle; throughput is 1 pair/cycle.
- in_ready is a registered function of state/counters and does not depend on in_valid.

## Configuration
- FP_DOT_OVF_FLAG_EN defined: `ovf` port exists. It sets when any product or partial sum has exponent 0xFF, stays set through DONE, and clears on the start handshake or on reset.
- Undefined: the `ovf` port and its logic are absent; arithmetic is identical.

## Test plan
- len=4, four pairs a=0x3F800000, b=0x40000000 on consecutive cycles → result=0x41000000, out_valid exactly MUL_STAGES+1 cycles after the last accept.
- start with len=0 → result=0x00000000, out_valid next cycle, in_ready never asserted.
- len=2, pairs (0x3FC00000, 0x3F800000) and (0xBFC00000, 0x3F800000) → result=0x00000000 (exact cancellation).
- len=3 with in_valid gapped randomly; out_ready held low 5 cycles in DONE → result stable and out_valid held, then IDLE after the handshake; a start during DONE is ignored.
- rst_n low for one cycle mid-ACCUM (2 of 4 pairs issued) → all outputs at reset values; a new len=1 run with (0x40400000, 0x40000000) → 0x40C00000.
- FP_DOT_OVF_FLAG_EN: len=1, a=b=0x7F000000 → result=0x7F800000, ovf=1; the next start clears ovf.

Source files
------------

// File: rtl/fp_dot_accum.sv
// -----------------------------------------------------------------------------
// fp_dot_accum
//
// Streaming fp32 dot-product engine. A start pulse in IDLE latches the vector
// length. The block then accepts that many operand pairs over a valid/ready
// stream and multiplies each pair in a MUL_STAGES-deep pipeline. Each product
// leaving the pipe is added into a running sum, and the final sum is held on a
// valid/ready result port until it is consumed.
//
// Arithmetic is a reduced fp32 subset:
//   - an exponent field of 0 is treated as zero (denormals flush to zero);
//   - products and sums are truncated, with no rounding;
//   - there is no NaN handling, so exponent 0xFF is an ordinary value.
//
// Optional feature: define FP_DOT_OVF_FLAG_EN to add the sticky `ovf` output.
//
// Parameters:
//   WIDTH       operand/result width; only 32 is legal
//   MUL_STAGES  multiplier pipeline depth (>= 1)
//   LEN_W       width of the vector-length input
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      begin a new dot product (sampled only in IDLE)
//   len        number of operand pairs, latched on an accepted start
//   busy       high in every state except IDLE
//   in_valid   operand pair valid
//   in_ready   operand pair accepted when in_valid && in_ready
//   a, b       fp32 operands
//   out_valid  result valid
//   out_ready  result consumed when out_valid && out_ready
//   result     fp32 accumulated sum
//   ovf        sticky overflow flag (FP_DOT_OVF_FLAG_EN only)
// -----------------------------------------------------------------------------
module fp_dot_accum #(
   parameter int WIDTH      = 32,
   parameter int MUL_STAGES = 2,
   parameter int LEN_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result
`ifdef FP_DOT_OVF_FLAG_EN
  ,output logic             ovf
`endif
);

   if (WIDTH != 32) begin : g_width_check
      $error("fp_dot_accum: WIDTH must be 32");
   end

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

   // The exponent sum is kept biased by an extra 127 so that all of the
   // arithmetic stays unsigned.
   function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
      logic [47:0] p;
      logic [9:0]  e2;
      logic [9:0]  eb;
      logic [22:0] m;
      logic        s;
      s  = x[31] ^ y[31];
      p  = {1'b1, x[22:0]} * {1'b1, y[22:0]};
      e2 = {2'b00, x[30:23]} + {2'b00, y[30:23]} + {9'd0, p[47]};
      eb = e2 - 10'd127;
      m  = p[47] ? p[46:24] : p[45:23];
      if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return 32'h0000_0000;
      if (e2 > 10'd381) return {s, 8'hFF, 23'd0};
      if (e2 < 10'd128) return {s, 31'd0};
      return {s, eb[7:0], m};
   endfunction

   // The operand with the larger magnitude supplies the sign and exponent.
   // The other operand is aligned into a 25-bit datapath (hidden bit,
   // 23 fraction bits, 1 guard bit), and the bits shifted out are dropped.
   function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
      logic [31:0] big;
      logic [31:0] sml;
      logic [7:0]  d;
      logic [24:0] mb;
      logic [24:0] ms;
      logic [25:0] sum;
      logic [8:0]  e;
      if (x[30:23] == 8'd0) return y;
      if (y[30:23] == 8'd0) return x;
      if (x[30:0] >= y[30:0]) begin
         big = x;
         sml = y;
      end else begin
         big = y;
         sml = x;
      end
      d  = big[30:23] - sml[30:23];
      mb = {1'b1, big[22:0], 1'b0};
      ms = {1'b1, sml[22:0], 1'b0} >> d;
      e  = {1'b0, big[30:23]};
      if (big[31] == sml[31]) begin
         sum = {1'b0, mb} + {1'b0, ms};
         if (sum[25]) begin
            sum = sum >> 1;
            e   = e + 9'd1;
         end
      end else begin
         sum = {1'b0, mb} - {1'b0, ms};
         if (sum == '0) return 32'h0000_0000;
         // Only a single left-shift step is applied.
         if (!sum[24]) begin
            sum = sum << 1;
            e   = e - 9'd1;
         end
      end
      if (e >= 9'd255) return {big[31], 8'hFF, 23'd0};
      return {big[31], e[7:0], sum[23:1]};
   endfunction

   state_t                  state, state_nxt;
   logic [LEN_W-1:0]        len_q;
   logic [LEN_W-1:0]        issued;
   logic [LEN_W-1:0]        retired;
   logic [WIDTH-1:0]        acc;
   logic [WIDTH-1:0]        pipe_data [MUL_STAGES];
   logic [MUL_STAGES-1:0]   pipe_vld;
   logic                    accept;
   logic                    start_hs;
   logic                    retire;
   logic [WIDTH-1:0]        prod;
   logic [WIDTH-1:0]        sum_next;

   assign accept   = in_valid && in_ready;
   assign start_hs = (state == IDLE) && start;
   assign retire   = pipe_vld[MUL_STAGES-1];
   assign prod     = pipe_data[MUL_STAGES-1];
   assign sum_next = fp_add(acc, prod);
   assign result   = acc;

   // NOTE: sequential state uses non-blocking assignments so that every
   // register samples the values from before the edge.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      busy      = (state != IDLE);
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_nxt = (len != '0) ? ACCUM : DONE;
         end
         ACCUM: begin
            in_ready = (issued < len_q);
            if (accept && (issued + LEN_W'(1) == len_q)) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (retired == len_q) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: the payload stages are not reset. Only the valid bits have to be
   // cleared, because a product is never used unless its valid bit is set.
   always_ff @(posedge clk) begin
      pipe_data[0] <= fp_mul(a, b);
      for (int i = 1; i < MUL_STAGES; i++) pipe_data[i] <= pipe_data[i-1];
   end

   // The pipe never stalls: a result cannot be presented while products
   // are still in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pipe_vld <= '0;
      end else begin
         pipe_vld[0] <= accept;
         for (int i = 1; i < MUL_STAGES; i++) pipe_vld[i] <= pipe_vld[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         len_q   <= '0;
         issued  <= '0;
         retired <= '0;
         acc     <= '0;
      end else if (start_hs) begin
         len_q   <= len;
         issued  <= '0;
         retired <= '0;
         acc     <= '0;
      end else begin
         if (accept) issued <= issued + LEN_W'(1);
         if (retire) begin
            acc     <= sum_next;
            retired <= retired + LEN_W'(1);
         end
      end
   end

`ifdef FP_DOT_OVF_FLAG_EN
   always_ff @(posedge clk) begin
      if (!rst_n)        ovf <= 1'b0;
      else if (start_hs) ovf <= 1'b0;
      else if (retire && (prod[30:23] == 8'hFF || sum_next[30:23] == 8'hFF))
                         ovf <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_fp_dot_accum.sv
// -----------------------------------------------------------------------------
// tb_fp_dot_accum
//
// Self-checking bench for fp_dot_accum. Each scenario task drives its own
// stimulus and compares the DUT against an integer-arithmetic model of the
// fp32 multiply/add rules. Inputs are driven, and outputs sampled, on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_fp_dot_accum;

   localparam int M = 2;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  len;
   logic        busy;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
`ifdef FP_DOT_OVF_FLAG_EN
   logic        ovf;
`endif

   int          vectors;
   int          miscompares;
   int          cyc = 0;
   logic [31:0] op_a [256];
   logic [31:0] op_b [256];

   fp_dot_accum #(.WIDTH(32), .MUL_STAGES(M), .LEN_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .result(result)
`ifdef FP_DOT_OVF_FLAG_EN
     ,.ovf(ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- reference model (value-level integer arithmetic) -------
   function automatic bit [31:0] m_mul(bit [31:0] x, bit [31:0] y);
      int     ex, ey, e;
      longint mx, my, p;
      bit     sgn;
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      sgn = x[31] ^ y[31];
      if (ex == 0 || ey == 0) return 32'h0;
      mx = 64'h80_0000 | longint'(x[22:0]);
      my = 64'h80_0000 | longint'(y[22:0]);
      p  = mx * my;
      e  = ex + ey - 127;
      if (p >= (64'd1 << 47)) begin
         p = p >> 24;
         e++;
      end else begin
         p = p >> 23;
      end
      if (e > 254) return {sgn, 8'hFF, 23'd0};
      if (e < 1)   return {sgn, 31'd0};
      return {sgn, e[7:0], p[22:0]};
   endfunction

   function automatic bit [31:0] m_add(bit [31:0] x, bit [31:0] y);
      int     ex, ey, e, d;
      longint mx, my, s, mag;
      bit     sgn;
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      if (ex == 0) return y;
      if (ey == 0) return x;
      mx = (64'h80_0000 | longint'(x[22:0])) << 1;
      my = (64'h80_0000 | longint'(y[22:0])) << 1;
      if (ex >= ey) begin
         e = ex;
         d = ex - ey;
         my = (d > 40) ? 0 : (my >> d);
      end else begin
         e = ey;
         d = ey - ex;
         mx = (d > 40) ? 0 : (mx >> d);
      end
      s = (x[31] ? -mx : mx) + (y[31] ? -my : my);
      if (s == 0) return 32'h0;
      sgn = (s < 0);
      mag = sgn ? -s : s;
      if (mag >= (64'd1 << 25)) begin
         mag = mag >> 1;
         e++;
      end else if (mag < (64'd1 << 24)) begin
         mag = mag << 1;
         e--;
      end
      if (e >= 255) return {sgn, 8'hFF, 23'd0};
      return {sgn, e[7:0], mag[23:1]};
   endfunction

   function automatic bit [31:0] model_dot(int n);
      bit [31:0] s;
      s = 32'h0;
      for (int i = 0; i < n; i++) s = m_add(s, m_mul(op_a[i], op_b[i]));
      return s;
   endfunction

   function automatic logic [31:0] rand_fp();
      logic       sg;
      logic [7:0] ex;
      sg = 1'($urandom_range(1));
      ex = 8'($urandom_range(134, 120));
      return {sg, ex, 23'($urandom)};
   endfunction

   // ---------------- stimulus driver (no checking) --------------------------
   // Runs one dot product from IDLE and stops at the first sample with
   // out_valid high. lat is the number of edges from the last pair accept (or
   // from the start edge when n==0) to the first sample with out_valid high.
   task automatic run_dot(input int n, input int gap_pct,
                          output logic [31:0] res, output int lat, output int iters,
                          output bit seen_ready, output bit tout);
      int k;
      int last_acc;
      int budget;
      bit hs;
      k = 0; iters = 0; seen_ready = 1'b0; tout = 1'b0; budget = 0;
      start = 1'b1;
      len   = 8'(n);
      @(negedge clk);
      start = 1'b0;
      last_acc = cyc;
      while (k < n && !tout) begin
         seen_ready |= in_ready;
         if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
         end else begin
            in_valid = 1'b1;
            a = op_a[k];
            b = op_b[k];
         end
         hs = in_valid && in_ready;
         @(negedge clk);
         iters++;
         if (hs) begin
            k++;
            last_acc = cyc;
         end
         if (iters > 2000) tout = 1'b1;
      end
      in_valid = 1'b0;
      while (!out_valid && !tout) begin
         seen_ready |= in_ready;
         @(negedge clk);
         budget++;
         if (budget > 200) tout = 1'b1;
      end
      seen_ready |= in_ready;
      lat = cyc - last_acc;
      res = result;
   endtask

   // ---------------- scenarios ----------------------------------------------
   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0;
      repeat (3) @(negedge clk);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL reset_result: got %h want 00000000", result); end
`ifdef FP_DOT_OVF_FLAG_EN
      vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL %s_out_valid_after_hs: got %b want 0", tag, out_valid); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL %s_busy_after_hs: got %b want 0", tag, busy); end
   endtask

   task automatic test_basic();
      logic [31:0] res; int lat, it; bit seen, tout;
      for (int i = 0; i < 4; i++) begin op_a[i] = 32'h3F80_0000; op_b[i] = 32'h4000_0000; end
      run_dot(4, 0, res, lat, it, seen, tout);
      vectors++; if (tout !== 1'b0) begin miscompares++; $display("FAIL basic_timeout: got %b want 0", tout); end
      vectors++; if (res !== 32'h4100_0000) begin miscompares++; $display("FAIL basic_result: got %h want 41000000", res); end
      vectors++; if (lat !== M + 1) begin miscompares++; $display("FAIL basic_latency: got %0d want %0d", lat, M + 1); end
      vectors++; if (it !== 4) begin miscompares++; $display("FAIL basic_throughput: got %0d cycles want 4", it); end
      handshake("basic");
   endtask

   task automatic test_len_zero();
      logic [31:0] res; int lat, it; bit seen, tout;
      run_dot(0, 0, res, lat, it, seen, tout);
      vectors++; if (tout !== 1'b0) begin miscompares++; $display("FAIL len0_timeout: got %b want 0", tout); end
      vectors++; if (res !== 32'h0) begin miscompares++; $display("FAIL len0_result: got %h want 00000000", res); end
      vectors++; if (lat !== 0) begin miscompares++; $display("FAIL len0_latency: got %0d want 0", lat); end
      vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL len0_in_ready: got %b want 0", seen); end
      handshake("len0");
   endtask

   task automatic test_cancel();
      logic [31:0] res; int lat, it; bit seen, tout;
      op_a[0] = 32'h3FC0_0000; op_b[0] = 32'h3F80_0000;
      op_a[1] = 32'hBFC0_0000; op_b[1] = 32'h3F80_0000;
      run_dot(2, 0, res, lat, it, seen, tout);
      vectors++; if (tout !== 1'b0) begin miscompares++; $display("FAIL cancel_timeout: got %b want 0", tout); end
      vectors++; if (res !== 32'h0) begin miscompares++; $display("FAIL cancel_result: got %h want 00000000", res); end
      handshake("cancel");
   endtask

   task automatic test_gapped_hold();
      logic [31:0] res, exp_r; int lat, it; bit seen, tout;
      for (int i = 0; i < 3; i++) begin op_a[i] = rand_fp(); op_b[i] = rand_fp(); end
      exp_r = model_dot(3);
      run_dot(3, 40, res, lat, it, seen, tout);
      vectors++; if (tout !== 1'b0) begin miscompares++; $display("FAIL gapped_timeout: got %b want 0", tout); end
      vectors++; if (res !== exp_r) begin miscompares++; $display("FAIL gapped_result: got %h want %h", res, exp_r); end
      vectors++; if (lat !== M + 1) begin miscompares++; $display("FAIL gapped_latency: got %0d want %0d", lat, M + 1); end
      // A start raised while the result is waiting must have no effect.
      start = 1'b1; len = 8'd5;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL hold_out_valid[%0d]: got %b want 1", c, out_valid); end
         vectors++; if (result !== exp_r) begin miscompares++; $display("FAIL hold_result[%0d]: got %h want %h", c, result, exp_r); end
      end
      start = 1'b0;
      handshake("hold");
      @(negedge clk);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL hold_idle_stays: got busy=%b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] res, exp_r; int lat, it, n; bit seen, tout;
      for (int r = 0; r < 6; r++) begin
         n = $urandom_range(20, 1);
         for (int i = 0; i < n; i++) begin op_a[i] = rand_fp(); op_b[i] = rand_fp(); end
         exp_r = model_dot(n);
         run_dot(n, 0, res, lat, it, seen, tout);
         vectors++; if (tout !== 1'b0) begin miscompares++; $display("FAIL b2b_timeout[%0d]: got %b want 0", r, tout); end
         vectors++; if (res !== exp_r) begin miscompares++; $display("FAIL b2b_result[%0d] n=%0d: got %h want %h", r, n, res, exp_r); end
         vectors++; if (lat !== M + 1) begin miscompares++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", r, lat, M + 1); end
         vectors++; if (it !== n) begin miscompares++; $display("FAIL b2b_throughput[%0d]: got %0d cycles want %0d", r, it, n); end
`ifdef FP_DOT_OVF_FLAG_EN
         vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL b2b_ovf[%0d]: got %b want 0", r, ovf); end
`endif
         handshake("b2b");
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] res; int lat, it; bit seen, tout;
      start = 1'b1; len = 8'd4;
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1; a = 32'h4000_0000; b = 32'h4000_0000;
      @(negedge clk);
      a = 32'h4040_0000; b = 32'h4040_0000;
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_in_ready: got %b want 0", in_ready); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
      vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL rstmid_result: got %h want 00000000", result); end
      repeat (M + 1) @(negedge clk);
      vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL rstmid_no_retire: got %h want 00000000", result); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_idle: got busy=%b want 0", busy); end
      op_a[0] = 32'h4040_0000; op_b[0] = 32'h4000_0000;
      run_dot(1, 0, res, lat, it, seen, tout);
      vectors++; if (tout !== 1'b0) begin miscompares++; $display("FAIL rstmid_timeout: got %b want 0", tout); end
      vectors++; if (res !== 32'h40C0_0000) begin miscompares++; $display("FAIL rstmid_rerun: got %h want 40c00000", res); end
      handshake("rstmid");
   endtask

   task automatic test_overflow();
      logic [31:0] res; int lat, it; bit seen, tout;
      op_a[0] = 32'h7F00_0000; op_b[0] = 32'h7F00_0000;
      run_dot(1, 0, res, lat, it, seen, tout);
      vectors++; if (tout !== 1'b0) begin miscompares++; $display("FAIL ovf_timeout: got %b want 0", tout); end
      vectors++; if (res !== 32'h7F80_0000) begin miscompares++; $display("FAIL ovf_result: got %h want 7f800000", res); end
`ifdef FP_DOT_OVF_FLAG_EN
      vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b want 1", ovf); end
`endif
      handshake("ovf");
`ifdef FP_DOT_OVF_FLAG_EN
      vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky_idle: got %b want 1", ovf); end
      start = 1'b1; len = 8'd1;
      @(negedge clk);
      start = 1'b0;
      vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_clear_on_start: got %b want 0", ovf); end
      in_valid = 1'b1; a = 32'h3F80_0000; b = 32'h3F80_0000;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (M + 1) @(negedge clk);
      vectors++; if (result !== 32'h3F80_0000) begin miscompares++; $display("FAIL ovf_next_result: got %h want 3f800000", result); end
      handshake("ovf_next");
`endif
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_basic();
      test_len_zero();
      test_cancel();
      test_gapped_hold();
      test_back_to_back();
      test_reset_mid();
      test_overflow();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
